// File: rtl/regfile_flags_if.sv
// ---------------------------------------------------------------------------
// regfile_flags_if
//
// Bundles the register-bank and flag-register signals shared between the
// control/ALU side (master) and the register file (slave).
//
// Signals:
//   we3, wa3, wd3        write enable, write address, write data (ALU R)
//   ra1, ra2             read addresses for ports 1 and 2
//   rd1, rd2             read data for ports 1 and 2 (ALU operands A/B)
//   flag_we              flag register capture enable
//   zero_in/carry_in/sign_in   ALU flags to capture
//   zero_q/carry_q/sign_q      registered flags
//   cond                 condition select for conditional jumps
//   cond_true            selected condition result
//
// Modports:
//   master  drives addresses, write data, flag inputs and cond
//   slave   the register file itself
// ---------------------------------------------------------------------------
interface regfile_flags_if #(
   parameter int WIDTH = 4,
   parameter int AW    = 4
);
   logic             we3;
   logic [AW-1:0]    wa3;
   logic [WIDTH-1:0] wd3;
   logic [AW-1:0]    ra1;
   logic [AW-1:0]    ra2;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;
   logic             flag_we;
   logic             zero_in;
   logic             carry_in;
   logic             sign_in;
   logic             zero_q;
   logic             carry_q;
   logic             sign_q;
   logic [1:0]       cond;
   logic             cond_true;

   modport master (
      output we3, wa3, wd3, ra1, ra2, flag_we, zero_in, carry_in, sign_in, cond,
      input  rd1, rd2, zero_q, carry_q, sign_q, cond_true
   );

   modport slave (
      input  we3, wa3, wd3, ra1, ra2, flag_we, zero_in, carry_in, sign_in, cond,
      output rd1, rd2, zero_q, carry_q, sign_q, cond_true
   );
endinterface

// File: rtl/regfile_flags.sv
// ---------------------------------------------------------------------------
// regfile_flags
//
// Register bank (NREG x WIDTH, two combinational read ports, one synchronous
// write port) plus a zero/carry/sign status-flag register and the condition
// selector used by the control unit for conditional jumps.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous active-high reset, clears registers and flags
//   bus    regfile_flags_if.slave (see interface file for signal list)
//
// Register 0 always reads as 0 and ignores writes.
//
// Optional build macro:
//   REGFILE_BYPASS_EN  when defined, a write to a non-zero address is
//                      forwarded to any read port addressing it in the same
//                      cycle (suppressed during reset). When undefined, reads
//                      return the old contents until the write edge.
// ---------------------------------------------------------------------------
module regfile_flags #(
   parameter int WIDTH = 4,
   parameter int NREG  = 16,
   parameter int AW    = 4
) (
   input  logic           clk,
   input  logic           reset,
   regfile_flags_if.slave bus
);

   logic [WIDTH-1:0] regs [NREG];
   logic             zero_r;
   logic             carry_r;
   logic             sign_r;
   logic [WIDTH-1:0] rd1_v;
   logic [WIDTH-1:0] rd2_v;
   logic             cond_v;

   // Register bank write port. Reset clears every entry (including entry 0,
   // so nothing in the array is ever left undefined). Writes to address 0
   // are dropped so that entry stays at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.we3 && (bus.wa3 != '0)) begin
         regs[bus.wa3] <= bus.wd3;
      end
   end

   // Flag register. Captures the ALU flags whenever flag_we is set,
   // independently of the register write; reset wins over capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         zero_r  <= 1'b0;
         carry_r <= 1'b0;
         sign_r  <= 1'b0;
      end else if (bus.flag_we) begin
         zero_r  <= bus.zero_in;
         carry_r <= bus.carry_in;
         sign_r  <= bus.sign_in;
      end
   end

   // Read ports. Address 0 is forced to zero explicitly rather than relying
   // on the stored entry. With the bypass build, an in-flight write to the
   // same non-zero address is forwarded, except while reset is asserted.
   always_comb begin
      rd1_v = (bus.ra1 == '0) ? '0 : regs[bus.ra1];
      rd2_v = (bus.ra2 == '0) ? '0 : regs[bus.ra2];
`ifdef REGFILE_BYPASS_EN
      if (!reset && bus.we3 && (bus.wa3 != '0)) begin
         if (bus.ra1 == bus.wa3) begin
            rd1_v = bus.wd3;
         end
         if (bus.ra2 == bus.wa3) begin
            rd2_v = bus.wd3;
         end
      end
`endif
   end

   // Condition selector. Looks only at the registered flags, so a capture
   // in this cycle influences cond_true from the next cycle onward.
   always_comb begin
      cond_v = 1'b1;
      case (bus.cond)
         2'b00:   cond_v = 1'b1;
         2'b01:   cond_v = zero_r;
         2'b10:   cond_v = carry_r;
         2'b11:   cond_v = sign_r;
         default: cond_v = 1'b1;
      endcase
   end

   assign bus.rd1       = rd1_v;
   assign bus.rd2       = rd2_v;
   assign bus.zero_q    = zero_r;
   assign bus.carry_q   = carry_r;
   assign bus.sign_q    = sign_r;
   assign bus.cond_true = cond_v;

endmodule

// File: tb/tb_regfile_flags.sv
// ---------------------------------------------------------------------------
// tb_regfile_flags
//
// Self-checking bench for regfile_flags: reset sequence, a table of directed
// vectors, the same-cycle read/write hazard, a full dual-port address sweep
// and a randomized run compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_regfile_flags;

   typedef struct {
      logic       rst;
      logic       we3;
      logic [3:0] wa3;
      logic [3:0] wd3;
      logic [3:0] ra1;
      logic [3:0] ra2;
      logic       flag_we;
      logic [2:0] fin;
      logic [1:0] cond;
      logic [3:0] e_rd1;
      logic [3:0] e_rd2;
      logic [2:0] e_flags;
      logic       e_ct;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   regfile_flags_if #(.WIDTH(4), .AW(4)) bus ();

   regfile_flags #(.WIDTH(4), .NREG(16), .AW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mkVec(logic rst, logic we, logic [3:0] wa, logic [3:0] wd,
                                  logic [3:0] r1, logic [3:0] r2, logic fwe,
                                  logic [2:0] fin, logic [1:0] cnd);
      vec_t v;
      v = '{default: '0};
      v.rst = rst; v.we3 = we; v.wa3 = wa; v.wd3 = wd;
      v.ra1 = r1; v.ra2 = r2; v.flag_we = fwe; v.fin = fin; v.cond = cnd;
      return v;
   endfunction

   // Drives one vector shortly after the falling edge so that combinational
   // outputs are settled and sampled well away from the rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      reset        = v.rst;
      bus.we3      = v.we3;
      bus.wa3      = v.wa3;
      bus.wd3      = v.wd3;
      bus.ra1      = v.ra1;
      bus.ra2      = v.ra2;
      bus.flag_we  = v.flag_we;
      bus.zero_in  = v.fin[2];
      bus.carry_in = v.fin[1];
      bus.sign_in  = v.fin[0];
      bus.cond     = v.cond;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic cycle(input vec_t v);
      applyStimulus(v);
      @(posedge clk);
   endtask

   vec_t       tbl [9];
   logic [3:0] mregs [16];
   logic [2:0] mflags;

   initial begin
      vec_t       v;
      logic [3:0] exp1;
      logic [3:0] exp2;
      logic       expct;

      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.we3 = 1'b0; bus.wa3 = '0; bus.wd3 = '0; bus.ra1 = '0; bus.ra2 = '0;
      bus.flag_we = 1'b0; bus.zero_in = 1'b0; bus.carry_in = 1'b0; bus.sign_in = 1'b0;
      bus.cond = 2'b00;

      // Initial reset, then preload every register with ~i and all flags set.
      cycle(mkVec(1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
      for (int i = 1; i < 16; i++) begin
         cycle(mkVec(0, 1, 4'(i), ~4'(i), 0, 0, 1, 3'b111, 2'b00));
      end

      // Reset cycle that also requests a write and a flag capture; reset wins.
      // Bypass is suppressed during reset, so reg[7] shows its old contents.
      applyStimulus(mkVec(1, 1, 4'd7, 4'h9, 4'd7, 4'd1, 1, 3'b111, 2'b01));
      checkOutput("reset_cycle_rd1", {4'h0, bus.rd1}, 8'h08);
      checkOutput("reset_cycle_rd2", {4'h0, bus.rd2}, 8'h0E);
      checkOutput("reset_cycle_ct", {7'h0, bus.cond_true}, 8'h01);
      @(posedge clk);

      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 3'b111, 2'b00));
      for (int a = 0; a < 16; a++) begin
         bus.ra1 = 4'(a);
         bus.ra2 = 4'(15 - a);
         #1;
         checkOutput("post_reset_rd1", {4'h0, bus.rd1}, 8'h00);
         checkOutput("post_reset_rd2", {4'h0, bus.rd2}, 8'h00);
      end
      checkOutput("post_reset_flags", {5'h0, bus.zero_q, bus.carry_q, bus.sign_q}, 8'h00);
      for (int c = 0; c < 4; c++) begin
         bus.cond = 2'(c);
         #1;
         checkOutput("post_reset_ct", {7'h0, bus.cond_true}, (c == 0) ? 8'h01 : 8'h00);
      end

      // Directed table: rst,we3,wa3,wd3,ra1,ra2,flag_we,fin,cond | rd1,rd2,flags,ct
      tbl[0] = '{0, 1, 4'd5, 4'hA, 4'd1, 4'd0, 0, 3'b000, 2'b00, 4'h0, 4'h0, 3'b000, 1};
      tbl[1] = '{0, 1, 4'd0, 4'hF, 4'd5, 4'd0, 0, 3'b000, 2'b01, 4'hA, 4'h0, 3'b000, 0};
      tbl[2] = '{0, 0, 4'd0, 4'h0, 4'd0, 4'd0, 1, 3'b101, 2'b01, 4'h0, 4'h0, 3'b000, 0};
      tbl[3] = '{0, 0, 4'd0, 4'h0, 4'd5, 4'd5, 0, 3'b010, 2'b01, 4'hA, 4'hA, 3'b101, 1};
      tbl[4] = '{0, 0, 4'd0, 4'h0, 4'd3, 4'd5, 0, 3'b000, 2'b10, 4'h0, 4'hA, 3'b101, 0};
      tbl[5] = '{0, 1, 4'd3, 4'h2, 4'd5, 4'd0, 0, 3'b000, 2'b11, 4'hA, 4'h0, 3'b101, 1};
      tbl[6] = '{0, 0, 4'd0, 4'h0, 4'd3, 4'd3, 1, 3'b010, 2'b00, 4'h2, 4'h2, 3'b101, 1};
      tbl[7] = '{0, 0, 4'd0, 4'h0, 4'd3, 4'd5, 0, 3'b000, 2'b10, 4'h2, 4'hA, 3'b010, 1};
      tbl[8] = '{0, 0, 4'd0, 4'h0, 4'd0, 4'd5, 0, 3'b111, 2'b01, 4'h0, 4'hA, 3'b010, 0};
      for (int k = 0; k < 9; k++) begin
         applyStimulus(tbl[k]);
         checkOutput($sformatf("tbl%0d_rd1", k), {4'h0, bus.rd1}, {4'h0, tbl[k].e_rd1});
         checkOutput($sformatf("tbl%0d_rd2", k), {4'h0, bus.rd2}, {4'h0, tbl[k].e_rd2});
         checkOutput($sformatf("tbl%0d_flags", k),
                     {5'h0, bus.zero_q, bus.carry_q, bus.sign_q}, {5'h0, tbl[k].e_flags});
         checkOutput($sformatf("tbl%0d_ct", k), {7'h0, bus.cond_true}, {7'h0, tbl[k].e_ct});
         @(posedge clk);
      end

      // Same-cycle read/write hazard on reg[3] (currently 2).
      applyStimulus(mkVec(0, 1, 4'd3, 4'h7, 4'd3, 4'd0, 0, 3'b000, 2'b00));
`ifdef REGFILE_BYPASS_EN
      checkOutput("hazard_same_cycle", {4'h0, bus.rd1}, 8'h07);
`else
      checkOutput("hazard_same_cycle", {4'h0, bus.rd1}, 8'h02);
`endif
      @(posedge clk);
      applyStimulus(mkVec(0, 0, 0, 0, 4'd3, 4'd0, 0, 3'b000, 2'b00));
      checkOutput("hazard_after_edge", {4'h0, bus.rd1}, 8'h07);

      // Dual-port sweep: reg[i] = i, then every address pair.
      for (int i = 1; i < 16; i++) begin
         cycle(mkVec(0, 1, 4'(i), 4'(i), 0, 0, 0, 3'b000, 2'b00));
      end
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            bus.ra1 = 4'(a);
            bus.ra2 = 4'(b);
            #1;
            checkOutput("sweep_rd1", {4'h0, bus.rd1}, 8'(a));
            checkOutput("sweep_rd2", {4'h0, bus.rd2}, 8'(b));
         end
      end

      // Randomized run against a behavioural model, starting from reset.
      cycle(mkVec(1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
      for (int i = 0; i < 16; i++) mregs[i] = 4'h0;
      mflags = 3'b000;
      for (int n = 0; n < 400; n++) begin
         v = mkVec(($urandom_range(0, 31) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom), 2'($urandom));
         applyStimulus(v);
         exp1 = (v.ra1 == 4'd0) ? 4'h0 : mregs[v.ra1];
         exp2 = (v.ra2 == 4'd0) ? 4'h0 : mregs[v.ra2];
`ifdef REGFILE_BYPASS_EN
         if (!v.rst && v.we3 && v.wa3 != 4'd0) begin
            if (v.ra1 == v.wa3) exp1 = v.wd3;
            if (v.ra2 == v.wa3) exp2 = v.wd3;
         end
`endif
         case (v.cond)
            2'b00:   expct = 1'b1;
            2'b01:   expct = mflags[2];
            2'b10:   expct = mflags[1];
            default: expct = mflags[0];
         endcase
         checkOutput("rand_rd1", {4'h0, bus.rd1}, {4'h0, exp1});
         checkOutput("rand_rd2", {4'h0, bus.rd2}, {4'h0, exp2});
         checkOutput("rand_flags", {5'h0, bus.zero_q, bus.carry_q, bus.sign_q}, {5'h0, mflags});
         checkOutput("rand_ct", {7'h0, bus.cond_true}, {7'h0, expct});
         @(posedge clk);
         if (v.rst) begin
            for (int i = 0; i < 16; i++) mregs[i] = 4'h0;
            mflags = 3'b000;
         end else begin
            if (v.we3 && v.wa3 != 4'd0) mregs[v.wa3] = v.wd3;
            if (v.flag_we) mflags = v.fin;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_flags.md
Name: regfile_flags

Overview:
- Register bank plus status-flag register feeding the 4-bit ALU.
- rd1/rd2 drive ALU operands A/B. ALU result R returns on wd3 for writeback; ALU zero/carry/sign are captured into the flag register.
- cond_true is the registered-flag condition consumed by the control unit for conditional jumps.
- Single clock domain, synchronous active-high reset.

Parameters:
WIDTH, 4, data width of each register, wd3, rd1, rd2.
NREG, 16, number of registers; must equal 2**AW.
AW, 4, register address width.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous active-high reset.
we3  input  1  register write enable.
wa3  input  AW  write address.
wd3  input  WIDTH  write data (ALU result R).
ra1  input  AW  read address, port 1.
ra2  input  AW  read address, port 2.
rd1  output  WIDTH  read data, port 1 (ALU A).
rd2  output  WIDTH  read data, port 2 (ALU B).
flag_we  input  1  flag register capture enable.
zero_in  input  1  ALU zero flag.
carry_in  input  1  ALU carry flag.
sign_in  input  1  ALU sign flag.
zero_q  output  1  registered zero flag.
carry_q  output  1  registered carry flag.
sign_q  output  1  registered sign flag.
cond  input  2  condition select.
cond_true  output  1  selected condition result.

Behaviour:
- Clock/reset (decided): one clock, clk. reset is synchronous and active-high.
- Reset: on a rising edge with reset=1, all registers clear to 0 and zero_q/carry_q/sign_q clear to 0.
  - Reset has priority over we3 and flag_we in the same cycle.
  - After reset, rd1=rd2=0 and cond_true=1 for cond=00, 0 otherwise.
- Register 0 is hardwired to 0:
  - Reads of address 0 return 0.
  - Writes to address 0 are discarded, even with we3=1.
- Write: on the rising edge with we3=1, wa3!=0 and reset=0, reg[wa3] <= wd3.
  - Value is visible on read ports after that edge, i.e. write-to-read latency is 1 cycle.
- Read: rd1=reg[ra1] and rd2=reg[ra2], combinational, 0 cycles.
  - ra1==ra2 is legal; both ports return the same value.
- Same-cycle read and write to the same address (base build): reads return the old contents until the edge.
- Flags: on the rising edge with flag_we=1 and reset=0, {zero_q,carry_q,sign_q} <= {zero_in,carry_in,sign_in}.
  - flag_we=0 holds the previous flags.
  - Flags are fully independent of we3; a compare (flags only, no write) uses flag_we=1, we3=0.
- cond_true, combinational from the registered flags:
  - 00: 1 (unconditional).
  - 01: zero_q.
  - 10: carry_q.
  - 11: sign_q.
- cond_true in the capture cycle reflects the pre-edge flags. The new flags affect cond_true one cycle after flag_we.
- No X propagation: every register has a defined value after the first reset edge.
- Width rule: data is stored unmodified. No sign extension or truncation occurs inside the block.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through bypass. If we3=1, wa3!=0 and ra1==wa3, then rd1=wd3 in the same cycle; likewise for rd2/ra2. The stored-register update still occurs at the edge.
- Defined, bypass exceptions:
  - Bypass is suppressed for address 0.
  - Bypass is suppressed while reset=1; reads then return the current register contents.
- Not defined: no bypass, base-build old-value semantics.

Test Plan:
- Reset with all registers preloaded -> one cycle reset=1 -> rd1/rd2 = 0 for every address 0..15; zero_q=carry_q=sign_q=0; cond=00 gives cond_true=1, cond=01..11 give 0.
- Write wa3=5, wd3=4'hA, we3=1 -> next cycle ra1=5 gives rd1=4'hA. Then write wa3=0, wd3=4'hF -> ra2=0 gives rd2=0.
- Same-cycle hazard: reg[3]=4'h2, then we3=1, wa3=3, wd3=4'h7, ra1=3.
  - Base build: rd1=4'h2 during the cycle, 4'h7 after the edge.
  - REGFILE_BYPASS_EN: rd1=4'h7 during the cycle.
- Flag capture: flag_we=1 with zero_in=1, carry_in=0, sign_in=1, cond=01 -> cond_true=0 in that cycle, 1 the next cycle. With flag_we=0 and new inputs 0/1/0, flags hold 1/0/1.
- Reset priority: reset=1, we3=1, wa3=7, wd3=4'h9, flag_we=1 with all flag inputs=1 -> after the edge reg[7]=0 and all flags 0.
- Dual-port sweep: write reg[i]=i for i=1..15 -> for every (ra1,ra2) pair, rd1=ra1 and rd2=ra2 (address 0 returns 0).
